// File: rtl/conv1_rgb_stage_if.sv
// Window/weight/result bundle for conv1_rgb_stage. The upstream or bench side
// uses the master modport; the convolution stage uses the slave modport.
interface conv1_rgb_stage_if #(
  parameter int bitsize = 14
);
  logic [9*bitsize-1:0] in_windowR;
  logic [9*bitsize-1:0] in_windowG;
  logic [9*bitsize-1:0] in_windowB;
  logic                 in_valid;
  logic                 w_wr_en;
  logic [4:0]           w_addr;
  logic [bitsize-1:0]   w_data;
  logic [bitsize-1:0]   out_pixel;
  logic                 out_valid;
  logic [6:0]           out_row;
  logic [6:0]           out_col;
  logic                 frame_done;

  modport master (
    output in_windowR, in_windowG, in_windowB, in_valid, w_wr_en, w_addr, w_data,
    input  out_pixel, out_valid, out_row, out_col, frame_done
  );

  modport slave (
    input  in_windowR, in_windowG, in_windowB, in_valid, w_wr_en, w_addr, w_data,
    output out_pixel, out_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/conv1_rgb_stage.sv
// 3x3x3 convolution for one stem output channel: window capture, multiply,
// per-channel sums, bias + saturate. CONV1_HSWISH_EN adds a hard-swish stage.
module conv1_rgb_stage #(
  parameter int bitsize     = 14,
  parameter int FRAC_BITS   = 7,
  parameter int window_size = 3,
  parameter int OUT_SIZE    = 112
) (
  input logic              clk,
  input logic              rst,
  conv1_rgb_stage_if.slave bus
);
  localparam int TAPS = window_size * window_size;
  localparam int NREG = 3 * TAPS + 1;
  localparam int PW   = 2 * bitsize;
  localparam int SW   = 2 * bitsize + 5;
  localparam logic [4:0] BIAS_ADDR = 5'(3 * TAPS);
  localparam logic [6:0] LAST      = 7'(OUT_SIZE - 1);

  typedef logic signed [bitsize-1:0] data_t;
  typedef logic signed [PW-1:0]      prod_t;
  typedef logic signed [SW-1:0]      sum_t;

  localparam sum_t SAT_MAX = sum_t'(2 ** (bitsize - 1) - 1);
  localparam sum_t SAT_MIN = ~SAT_MAX;

  function automatic data_t saturate(input sum_t v);
    if (v > SAT_MAX) return data_t'(SAT_MAX);
    if (v < SAT_MIN) return data_t'(SAT_MIN);
    return data_t'(v);
  endfunction

  // Writes are delayed one cycle so the window captured on the write edge
  // still multiplies against the old bank.
  logic       wr_en_q, wr_en_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  data_t      wr_data_q, wr_data_d;
  data_t      wbank_q [NREG];
  data_t      wbank_d [NREG];

  data_t win_q  [3][TAPS];
  data_t win_d  [3][TAPS];
  prod_t prod_q [3][TAPS];
  prod_t prod_d [3][TAPS];
  sum_t  psum_q [3];
  sum_t  psum_d [3];
  data_t bias1_q, bias1_d, bias2_q, bias2_d;
  data_t sat_d;

  logic [2:0] vld_q, vld_d;
  data_t      out_pixel_q, out_pixel_d;
  logic       out_valid_q, out_valid_d;
  logic [6:0] col_q, col_d, row_q, row_d;

`ifdef CONV1_HSWISH_EN
  data_t x_q, x_d;
  logic  x_valid_q, x_valid_d;

  function automatic data_t hswish(input data_t x);
    int r;
    int y;
    r = int'(x) + (3 <<< FRAC_BITS);
    if (r < 0) r = 0;
    else if (r > (6 <<< FRAC_BITS)) r = 6 <<< FRAC_BITS;
    y = ((int'(x) * r) >>> FRAC_BITS) / 6;
    return saturate(sum_t'(y));
  endfunction
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    sum_t total;
    wr_en_d   = bus.w_wr_en;
    wr_addr_d = bus.w_addr;
    wr_data_d = bus.w_data;
    wbank_d   = wbank_q;
    if (wr_en_q && wr_addr_q <= BIAS_ADDR) wbank_d[wr_addr_q] = wr_data_q;

    for (int k = 0; k < TAPS; k++) begin
      win_d[0][k] = bus.in_windowR[k*bitsize +: bitsize];
      win_d[1][k] = bus.in_windowG[k*bitsize +: bitsize];
      win_d[2][k] = bus.in_windowB[k*bitsize +: bitsize];
    end

    // Arithmetic shift gives floor rounding of the Q-format product.
    for (int c = 0; c < 3; c++) begin
      psum_d[c] = '0;
      for (int k = 0; k < TAPS; k++) begin
        prod_d[c][k] = (prod_t'(win_q[c][k]) * prod_t'(wbank_q[c*TAPS+k])) >>> FRAC_BITS;
        psum_d[c]    = psum_d[c] + sum_t'(prod_q[c][k]);
      end
    end
    bias1_d = wbank_q[NREG-1];
    bias2_d = bias1_q;

    total = psum_q[0] + psum_q[1] + psum_q[2] + sum_t'(bias2_q);
    sat_d = saturate(total);
    vld_d = {vld_q[1:0], bus.in_valid};

`ifdef CONV1_HSWISH_EN
    x_valid_d   = vld_q[2];
    x_d         = vld_q[2] ? sat_d : x_q;
    out_valid_d = x_valid_q;
    out_pixel_d = x_valid_q ? hswish(x_q) : out_pixel_q;
`else
    out_valid_d = vld_q[2];
    out_pixel_d = vld_q[2] ? sat_d : out_pixel_q;
`endif

    col_d = col_q;
    row_d = row_q;
    if (out_valid_q) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 7'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NREG; i++) wbank_q[i] <= '0;
      vld_q       <= '0;
      out_pixel_q <= '0;
      out_valid_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
`ifdef CONV1_HSWISH_EN
      x_q         <= '0;
      x_valid_q   <= 1'b0;
`endif
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wbank_q     <= wbank_d;
      vld_q       <= vld_d;
      out_pixel_q <= out_pixel_d;
      out_valid_q <= out_valid_d;
      col_q       <= col_d;
      row_q       <= row_d;
`ifdef CONV1_HSWISH_EN
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
`endif
    end
  end

  // NOTE: datapath registers carry no reset; the valid pipeline alone decides
  // whether their contents are ever observed.
  always_ff @(posedge clk) begin
    win_q   <= win_d;
    prod_q  <= prod_d;
    psum_q  <= psum_d;
    bias1_q <= bias1_d;
    bias2_q <= bias2_d;
  end

  assign bus.out_pixel  = out_pixel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_row    = row_q;
  assign bus.out_col    = col_q;
  assign bus.frame_done = out_valid_q && (col_q == LAST) && (row_q == LAST);
endmodule
